// File: rtl/cog_loader.sv
// Cog RAM loader: copies COUNT consecutive hub longs into cog RAM port B
// at addresses 0..COUNT-1 over a req/ack hub handshake, then pulses done.
module cog_loader #(
  parameter int unsigned COUNT = 496,
  parameter int unsigned HAW   = 14
) (
  input  logic           clk,
  input  logic           nres,
  input  logic           start,
  input  logic           abort,
  input  logic [HAW-1:0] ptr,
  output logic           busy,
  output logic           done,
  output logic           hub_req,
  output logic [HAW-1:0] hub_addr,
  input  logic           hub_ack,
  input  logic [31:0]    hub_data,
  output logic           ram_ena,
  output logic           ram_w,
  output logic [8:0]     ram_a,
  output logic [31:0]    ram_d
);

  localparam int unsigned   IAW      = 9;
  localparam logic [IAW-1:0] LAST_IDX = IAW'(COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e         r_state, w_state_nxt;
  logic [HAW-1:0] r_base, w_base_nxt;
  logic [IAW-1:0] r_idx, w_idx_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           r_hub_req, w_hub_req_nxt;
  logic [HAW-1:0] r_hub_addr, w_hub_addr_nxt;
  logic           r_ram_ena, w_ram_ena_nxt;
  logic           r_ram_w, w_ram_w_nxt;
  logic [IAW-1:0] r_ram_a, w_ram_a_nxt;
  logic [31:0]    r_ram_d, w_ram_d_nxt;

  logic [IAW-1:0] w_idx_inc;
  logic           w_last;

  assign w_idx_inc = r_idx + IAW'(1);
  assign w_last    = (r_idx == LAST_IDX);

  // State and registered outputs
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hub_req  <= 1'b0;
      r_hub_addr <= '0;
      r_ram_ena  <= 1'b0;
      r_ram_w    <= 1'b0;
      r_ram_a    <= '0;
      r_ram_d    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_base     <= w_base_nxt;
      r_idx      <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_hub_req  <= w_hub_req_nxt;
      r_hub_addr <= w_hub_addr_nxt;
      r_ram_ena  <= w_ram_ena_nxt;
      r_ram_w    <= w_ram_w_nxt;
      r_ram_a    <= w_ram_a_nxt;
      r_ram_d    <= w_ram_d_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !abort) w_state_nxt = S_REQ;
      S_REQ: begin
        if (abort)        w_state_nxt = S_IDLE;
        else if (hub_ack) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (abort || w_last) w_state_nxt = S_IDLE;
        else                 w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of datapath and outputs; RAM strobes and done are one-cycle
  always_comb begin
    w_base_nxt     = r_base;
    w_idx_nxt      = r_idx;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_hub_req_nxt  = r_hub_req;
    w_hub_addr_nxt = r_hub_addr;
    w_ram_ena_nxt  = 1'b0;
    w_ram_w_nxt    = 1'b0;
    w_ram_a_nxt    = r_ram_a;
    w_ram_d_nxt    = r_ram_d;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_base_nxt     = ptr;
          w_idx_nxt      = '0;
          w_hub_req_nxt  = 1'b1;
          w_hub_addr_nxt = ptr;
          w_busy_nxt     = 1'b1;
        end
      end
      S_REQ: begin
        if (abort) begin
          w_hub_req_nxt  = 1'b0;
          w_hub_addr_nxt = '0;
          w_busy_nxt     = 1'b0;
          w_ram_a_nxt    = '0;
          w_ram_d_nxt    = '0;
        end else if (hub_ack) begin
          w_hub_req_nxt = 1'b0;
          w_ram_ena_nxt = 1'b1;
          w_ram_w_nxt   = 1'b1;
          w_ram_a_nxt   = r_idx;
          w_ram_d_nxt   = hub_data;
        end
      end
      S_WRITE: begin
        if (abort) begin
          w_busy_nxt     = 1'b0;
          w_hub_req_nxt  = 1'b0;
          w_hub_addr_nxt = '0;
          w_ram_a_nxt    = '0;
          w_ram_d_nxt    = '0;
        end else if (w_last) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else begin
          w_idx_nxt      = w_idx_inc;
          w_hub_addr_nxt = r_base + HAW'(w_idx_inc);
          w_hub_req_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hub_req  = r_hub_req;
  assign hub_addr = r_hub_addr;
  assign ram_ena  = r_ram_ena;
  assign ram_w    = r_ram_w;
  assign ram_a    = r_ram_a;
  assign ram_d    = r_ram_d;

endmodule

// File: tb/tb_cog_loader.sv
// Directed bench for cog_loader: hub responder model, RAM write monitor,
// hand-computed cycle counts and address/data sequences.
module tb_cog_loader;

  localparam int unsigned COUNT = 496;
  localparam int unsigned HAW   = 14;

  logic           clk = 1'b0;
  logic           nres, start, abort;
  logic [HAW-1:0] ptr;
  logic           busy, done, hub_req, hub_ack;
  logic [HAW-1:0] hub_addr;
  logic [31:0]    hub_data, ram_d;
  logic           ram_ena, ram_w;
  logic [8:0]     ram_a;
  logic [59:0]    all_outs;

  always #5 clk = ~clk;

  cog_loader #(.COUNT(COUNT), .HAW(HAW)) u_dut (
    .clk(clk), .nres(nres), .start(start), .abort(abort), .ptr(ptr),
    .busy(busy), .done(done), .hub_req(hub_req), .hub_addr(hub_addr),
    .hub_ack(hub_ack), .hub_data(hub_data),
    .ram_ena(ram_ena), .ram_w(ram_w), .ram_a(ram_a), .ram_d(ram_d)
  );

  assign all_outs = {busy, done, hub_req, hub_addr, ram_ena, ram_w, ram_a, ram_d};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [HAW-1:0] a);
    return {18'd0, a} ^ 32'hA5A5_0000;
  endfunction

  // Hub responder: ack after wcnt wait cycles; optional spurious acks while idle
  int max_wait = 0;
  int wcnt     = 0;
  int wait_sum = 0;
  bit spur     = 1'b0;

  initial begin
    hub_ack  = 1'b0;
    hub_data = '0;
    forever begin
      @(negedge clk);
      hub_ack  = 1'b0;
      hub_data = '0;
      if (hub_req) begin
        if (wcnt == 0) begin
          hub_ack  = 1'b1;
          hub_data = exp_data(hub_addr);
          wcnt     = int'($urandom_range(max_wait, 0));
        end else begin
          wcnt--;
          wait_sum++;
        end
      end else if (spur) begin
        hub_ack  = 1'b1;
        hub_data = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: RAM writes, request addresses, protocol violations
  logic [8:0]     wr_a[$];
  logic [31:0]    wr_d[$];
  logic [HAW-1:0] rq_a[$];
  int             proto_bad = 0;
  logic           prev_req  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (ram_ena && ram_w) begin
        wr_a.push_back(ram_a);
        wr_d.push_back(ram_d);
      end
      if (ram_w != ram_ena)   proto_bad++;
      if (hub_req && ram_ena) proto_bad++;
      if (hub_req && !prev_req) rq_a.push_back(hub_addr);
      prev_req = hub_req;
    end
  end

  task automatic check_writes(input string tag, input logic [HAW-1:0] p, input int n);
    int bad_w;
    int bad_r;
    bad_w = 0;
    bad_r = 0;
    chk({tag, "_nwr"}, 64'(wr_a.size()), 64'(n));
    chk({tag, "_nreq"}, 64'(rq_a.size()), 64'(n));
    for (int i = 0; i < wr_a.size() && i < n; i++)
      if (wr_a[i] !== 9'(i) || wr_d[i] !== exp_data(p + HAW'(i))) bad_w++;
    for (int i = 0; i < rq_a.size() && i < n; i++)
      if (rq_a[i] !== p + HAW'(i)) bad_r++;
    chk({tag, "_wr_bad"}, 64'(bad_w), 64'd0);
    chk({tag, "_req_bad"}, 64'(bad_r), 64'd0);
  endtask

  // mode 0: run to done; 1: abort in REQ of idx 3; 2: abort in WRITE of idx 3
  task automatic run_load(input logic [HAW-1:0] p, input int mode, input int poke,
                          output int edges, output int busy_n, output bit got_done);
    int lim;
    int ab_at;
    lim   = (mode != 0) ? 40 : 8000;
    ab_at = -1;
    wr_a.delete();
    wr_d.delete();
    rq_a.delete();
    wcnt     = 0;
    wait_sum = 0;
    start    = 1'b1;
    ptr      = p;
    @(negedge clk);
    start = 1'b0;
    ptr   = 14'h1555;
    chk("start_acc", 64'({busy, done}), 64'b10);
    edges    = 0;
    busy_n   = busy ? 1 : 0;
    got_done = 1'b0;
    while (edges < lim) begin
      @(negedge clk);
      edges++;
      if (start) start = 1'b0;
      if (ab_at >= 0 && edges == ab_at + 1) begin
        abort = 1'b0;
        if (mode == 1) chk("abort_req_outs", 64'({hub_req, busy, done}), 64'd0);
        else           chk("abort_wr_outs", 64'(all_outs), 64'd0);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (edges == poke) begin
        start = 1'b1;
        ptr   = 14'h2000;
      end
      if (ab_at < 0 &&
          ((mode == 1 && hub_req && hub_addr == p + HAW'(3)) ||
           (mode == 2 && ram_ena && ram_a == 9'd3))) begin
        abort = 1'b1;
        ab_at = edges;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int e, b;
    bit d;
    int bad;
    nres  = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    ptr   = 14'h0155;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'(all_outs), 64'd0);
    start = 1'b0;
    nres  = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 64'({busy, hub_req, ram_ena}), 64'd0);

    // start and abort together in IDLE: nothing starts
    start = 1'b1;
    abort = 1'b1;
    ptr   = 14'h0077;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'({busy, hub_req, ram_ena}), 64'd0);

    // acks with no request outstanding
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    chk("spur_ack_idle", 64'({busy, hub_req, ram_ena, ram_w}), 64'd0);

    // Full zero-wait load, start re-pulsed with a new ptr mid-load
    run_load(14'h0100, 0, 101, e, b, d);
    chk("full_done", 64'(d), 64'd1);
    chk("full_edges", 64'(e), 64'd992);
    chk("full_busy_cycles", 64'(b), 64'd992);
    check_writes("full", 14'h0100, 496);

    // Back-to-back load starting right after done, hub address wraps
    run_load(14'h3FFE, 0, -1, e, b, d);
    chk("wrap_done", 64'(d), 64'd1);
    chk("wrap_edges", 64'(e), 64'd992);
    if (rq_a.size() >= 4) begin
      chk("wrap_req0", 64'(rq_a[0]), 64'h3FFE);
      chk("wrap_req1", 64'(rq_a[1]), 64'h3FFF);
      chk("wrap_req2", 64'(rq_a[2]), 64'h0000);
      chk("wrap_req3", 64'(rq_a[3]), 64'h0001);
    end else begin
      chk("wrap_req_count", 64'(rq_a.size()), 64'd4);
    end
    check_writes("wrap", 14'h3FFE, 496);
    @(negedge clk);
    chk("wrap_done_width", 64'(done), 64'd0);

    // Random hub wait states with spurious acks between requests
    max_wait = 5;
    spur     = 1'b1;
    run_load(14'h0300, 0, -1, e, b, d);
    spur     = 1'b0;
    max_wait = 0;
    chk("ws_done", 64'(d), 64'd1);
    chk("ws_edges", 64'(e), 64'(992 + wait_sum));
    check_writes("ws", 14'h0300, 496);
    @(negedge clk);
    chk("ws_done_width", 64'(done), 64'd0);

    // Abort in REQ of idx 3 (ack coincides): writes 0..2 only
    run_load(14'h0400, 1, -1, e, b, d);
    chk("abreq_done", 64'(d), 64'd0);
    chk("abreq_nwr", 64'(wr_a.size()), 64'd3);
    bad = 0;
    for (int i = 0; i < wr_a.size(); i++)
      if (wr_a[i] !== 9'(i) || wr_d[i] !== exp_data(14'h0400 + HAW'(i))) bad++;
    chk("abreq_wr_bad", 64'(bad), 64'd0);

    // Abort in WRITE of idx 3: write 3 lands, no done
    run_load(14'h0500, 2, -1, e, b, d);
    chk("abwr_done", 64'(d), 64'd0);
    chk("abwr_nwr", 64'(wr_a.size()), 64'd4);
    if (wr_a.size() >= 4) begin
      chk("abwr_a3", 64'(wr_a[3]), 64'd3);
      chk("abwr_d3", 64'(wr_d[3]), 64'(exp_data(14'h0503)));
    end

    // Fresh load after aborts
    run_load(14'h0600, 0, -1, e, b, d);
    chk("restart_done", 64'(d), 64'd1);
    chk("restart_edges", 64'(e), 64'd992);
    check_writes("restart", 14'h0600, 496);

    // Reset mid-load
    @(negedge clk);
    start = 1'b1;
    ptr   = 14'h0700;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("midload_busy", 64'(busy), 64'd1);
    nres = 1'b0;
    #1;
    chk("midload_rst_outs", 64'(all_outs), 64'd0);
    @(negedge clk);
    nres = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy || hub_req) bad++;
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);

    chk("protocol_violations", 64'(proto_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
